fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling queue between `if_stage` and the decode stage. It holds fetched instructions with their PC and misalignment flag in a small circular FIFO and hands them to decode over a valid/ready handshake. It is flushed whenever a branch/jump or exception redirect is taken, so no wrong-path instruction reaches decode. Reset is asynchronous and active-low.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; must be a power of two, ≥ 2.
- `PTR_W`, default 2: pointer width, equal to log2(DEPTH).

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `flush`  input  1  redirect this cycle; driven with `bj_ena | excp_jmp_ena`.
- `in_valid`  input  1  fetch side holds a valid instruction.
- `in_ready`  output  1  queue accepts an entry this cycle.
- `in_pc`  input  64  PC of the fetched instruction.
- `in_inst`  input  32  instruction word.
- `in_misal`  input  1  instruction-address-misaligned flag.
- `out_valid`  output  1  head entry is valid for decode.
- `out_ready`  input  1  decode consumes the head this cycle.
- `out_pc`  output  64  head PC.
- `out_inst`  output  32  head instruction.
- `out_misal`  output  1  head misalignment flag.
- `count`  output  PTR_W+1  number of occupied entries.

## Operation
- Storage: DEPTH entries of {pc[63:0], inst[31:0], misal}. Write pointer `wp`, read pointer `rp` (PTR_W bits, wrap modulo DEPTH), occupancy `count` (0..DEPTH).
- Push = `in_valid & in_ready`: write the entry at `wp`, then `wp+1`.
- Pop = `out_valid & out_ready`: `rp+1`.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- `in_ready = (count != DEPTH) & ~flush`. No push while full, even if a pop happens in the same cycle.
- `out_valid = (count != 0) & ~flush`.
- `out_*` always show the entry at `rp`. Their value is don't-care when `out_valid = 0`.
- Flush (synchronous, highest priority): `wp`, `rp` and `count` go to 0. Any push or pop in the same cycle is ignored. Entry contents are not cleared.
- Pointer wrap-around: the pointer goes from DEPTH−1 to 0 with no bubble.
- Arithmetic: pointer increment truncates to PTR_W bits. `count` never exceeds DEPTH and never underflows; handshake gating guarantees both.

## Timing
- Reset (`rst` = 0, asynchronous): `wp = rp = count = 0` and all storage = 0.
  - Resulting outputs: `out_valid = 0`; `in_ready = 1` once `flush = 0`; `out_pc = 0`, `out_inst = 0`, `out_misal = 0`; `count = 0`.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency without bypass: an entry pushed at edge N is visible on `out_*` with `out_valid = 1` after edge N. Minimum latency is 1 cycle.
- Throughput: 1 entry/cycle in steady state when 0 < count < DEPTH.
- Flush cycle: `in_ready = 0` and `out_valid = 0` combinationally. The queue is empty after the edge; the first post-flush push is visible one cycle later.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When `count == 0`, `in_valid = 1` and `flush = 0`: `out_valid = 1` and `out_*` = `in_*` combinationally (0-cycle latency).
  - If `out_ready = 1` in that cycle, the entry is consumed and not stored; `count` stays 0.
  - If `out_ready = 0`, the entry is pushed normally.
- `FETCHQ_BYPASS_EN` undefined: no combinational path from `in_*` to `out_*`. Behaviour is exactly as in Operation/Timing.

## Test plan
- Reset: hold `rst = 0` with random inputs → `out_valid = 0`, `count = 0`, `out_pc = 0`. Release with `flush = 0` → `in_ready = 1`.
- Fill/drain: push PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000C with `out_ready = 0` → `count = 4`, `in_ready = 0`. Then `out_ready = 1` for 4 cycles → popped in that order, `count = 0`, `out_valid = 0`.
- Wrap-around streaming: continuous `in_valid = 1` and `out_ready = 1` for 10 entries after one pre-fill → every PC is delivered in order with no gaps; `count` holds at 1.
- Flush priority: `count = 3` and `flush = 1` with `in_valid = 1` and `out_ready = 1` → `in_ready = 0` and `out_valid = 0` that cycle; `count = 0` next cycle; the pushed entry never appears.
- Misalignment propagation: push pc 0x80000002 with `in_misal = 1` → `out_misal = 1` with `out_pc = 0x80000002`.
- Bypass (with `FETCHQ_BYPASS_EN`): empty queue, `in_valid = 1`, `out_ready = 1`, `in_pc = 0x80000010` → `out_valid = 1` and `out_pc = 0x80000010` in the same cycle; `count` stays 0. Without the macro → `out_valid = 0` that cycle, and the entry appears one cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
`timescale 1ns/1ps
// fetch_queue_if: handshake bundle between fetch (master) and the fetch queue (slave).
// The same bundle carries the decode-side output handshake; the queue owns the out_* drivers.
// in_*  : fetch -> queue (in_ready back); out_* : queue -> decode (out_ready back).
interface fetch_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_inst;
  logic        in_misal;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_misal;

  modport master (
    output in_valid, in_pc, in_inst, in_misal, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_misal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_misal, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_misal
  );
endinterface

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue: circular FIFO of {pc, inst, misal} decoupling fetch from decode; flushed on redirect.
// Latency: 1 cycle push-to-head; 0 cycles on an empty queue when FETCHQ_BYPASS_EN is defined.
// Backpressure: in_ready drops when full or flushing; a full queue refuses pushes even if popping.
// Ports: clk, rst (async, active-low), flush (redirect), fq (slave side of fetch_queue_if),
//        count (occupancy, 0..DEPTH). Optional macro: FETCHQ_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  fetch_queue_if.slave   fq,
  output logic [PTR_W:0] count
);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        misal;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [PTR_W:0]   r_count;

  logic   w_full;
  logic   w_empty;
  logic   w_byp;
  logic   w_push;
  logic   w_pop;
  logic   w_store;
  logic   w_deq;
  entry_t w_in;
  entry_t w_head;

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_in    = {fq.in_pc, fq.in_inst, fq.in_misal};

`ifdef FETCHQ_BYPASS_EN
  // Empty queue forwards the incoming entry straight to decode. Held off
  // during reset so decode never sees a valid while the queue is reset.
  assign w_byp = w_empty & fq.in_valid & ~flush & rst;
`else
  assign w_byp = 1'b0;
`endif

  assign fq.in_ready  = ~w_full & ~flush;
  assign fq.out_valid = (~w_empty & ~flush) | w_byp;

  assign w_head       = w_byp ? w_in : r_mem[r_rp];
  assign fq.out_pc    = w_head.pc;
  assign fq.out_inst  = w_head.inst;
  assign fq.out_misal = w_head.misal;

  assign w_push = fq.in_valid & fq.in_ready;
  assign w_pop  = fq.out_valid & fq.out_ready;

  // A bypassed entry that decode takes immediately is never written; a
  // bypassed entry decode refuses is stored like any other push. Only
  // non-bypass pops consume a stored entry.
  assign w_store = w_push & ~(w_byp & fq.out_ready);
  assign w_deq   = w_pop & ~w_byp;

  assign count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_wp <= r_wp + PTR_W'(1);
      if (w_deq)   r_rp <= r_rp + PTR_W'(1);
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entries are only cleared by reset; flush just rewinds the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_store) begin
      r_mem[r_wp] <= w_in;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        misal;
  } ent_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic [PTR_W:0] count;

  fetch_queue_if fq();

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .fq    (fq),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  ent_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a plain queue of entries, advanced on each clock edge.
  int   m_sz;
  bit   m_byp, m_vld, m_rdy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      m_sz  = mq.size();
      m_byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      m_byp = (m_sz == 0) && fq.in_valid;
`endif
      m_rdy = (m_sz != DEPTH);
      m_vld = (m_sz != 0) || m_byp;
      if (!(m_byp && fq.out_ready)) begin
        if (m_vld && fq.out_ready) void'(mq.pop_front());
        if (fq.in_valid && m_rdy)
          mq.push_back('{pc: fq.in_pc, inst: fq.in_inst, misal: fq.in_misal});
      end
    end
  end

  // Compare process: every cycle, on the falling edge.
  int   c_sz;
  bit   c_byp, c_vld, c_rdy;
  ent_t c_head;
  always @(negedge clk) begin
    c_sz  = mq.size();
    c_byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    c_byp = (c_sz == 0) && rst && fq.in_valid && !flush;
`endif
    c_rdy = (c_sz != DEPTH) && !flush;
    c_vld = ((c_sz != 0) && !flush) || c_byp;
    chk("m_in_ready", fq.in_ready, c_rdy);
    chk("m_out_valid", fq.out_valid, c_vld);
    chk("m_count", count, c_sz);
    if (c_vld) begin
      c_head = c_byp ? ent_t'{pc: fq.in_pc, inst: fq.in_inst, misal: fq.in_misal} : mq[0];
      chk("m_out_pc", fq.out_pc, c_head.pc);
      chk("m_out_inst", fq.out_inst, c_head.inst);
      chk("m_out_misal", fq.out_misal, c_head.misal);
    end
  end

  // One cycle of stimulus; returns just after the falling edge so outputs are settled.
  task automatic drive(input logic v, input logic [63:0] pc, input logic m,
                       input logic ordy, input logic fl);
    @(posedge clk); #1;
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_inst   = pc[31:0] ^ 32'h0000_0013;
    fq.in_misal  = m;
    fq.out_ready = ordy;
    flush        = fl;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    fq.in_valid = 1'b0; fq.in_pc = '0; fq.in_inst = '0; fq.in_misal = 1'b0;
    fq.out_ready = 1'b0; flush = 1'b0;

    // Reset held with random inputs (flush kept low so in_ready is defined).
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1) == 1, {$urandom(), $urandom()}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 1'b0);
      chk("rst_out_valid", fq.out_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_out_pc", fq.out_pc, 64'h0);
    end
    @(posedge clk); #1;
    rst = 1'b1; fq.in_valid = 1'b0; fq.out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    chk("rel_in_ready", fq.in_ready, 1'b1);

    // Fill to full, then drain in order; a push offered while full is refused.
    for (int i = 0; i < 4; i++) drive(1'b1, 64'h8000_0000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h9000_0000, 1'b0, 1'b1, 1'b0);
    chk("full_count", count, 4);
    chk("full_in_ready", fq.in_ready, 1'b0);
    chk("drain0_pc", fq.out_pc, 64'h8000_0000);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
      chk("drain_valid", fq.out_valid, 1'b1);
      chk("drain_pc", fq.out_pc, 64'h8000_0000 + 64'(4 * i));
      if (i == 1) chk("no_push_full", count, 3);
    end
    idle();
    chk("drained_count", count, 0);
    chk("drained_valid", fq.out_valid, 1'b0);

    // Streaming across pointer wrap with one entry pre-filled.
    drive(1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h8000_1004 + 64'(4 * i), 1'b0, 1'b1, 1'b0);
      chk("strm_valid", fq.out_valid, 1'b1);
      chk("strm_pc", fq.out_pc, 64'h8000_1000 + 64'(4 * i));
      chk("strm_count", count, 1);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("strm_last_pc", fq.out_pc, 64'h8000_1028);
    idle();
    chk("strm_end_count", count, 0);

    // Flush wins over a simultaneous push and pop.
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h8000_2000 + 64'(4 * i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'h0000_0BAD, 1'b0, 1'b1, 1'b1);
    chk("fl_count_pre", count, 3);
    chk("fl_in_ready", fq.in_ready, 1'b0);
    chk("fl_out_valid", fq.out_valid, 1'b0);
    idle();
    chk("fl_count_post", count, 0);
    chk("fl_valid_post", fq.out_valid, 1'b0);
    drive(1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("fl_next_valid", fq.out_valid, 1'b1);
    chk("fl_next_pc", fq.out_pc, 64'h8000_3000);
    idle();

    // Misalignment flag travels with its entry.
    drive(1'b1, 64'h8000_0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("mis_valid", fq.out_valid, 1'b1);
    chk("mis_pc", fq.out_pc, 64'h8000_0002);
    chk("mis_flag", fq.out_misal, 1'b1);
    idle();

    // Empty queue offered an entry with decode ready.
    drive(1'b1, 64'h8000_0010, 1'b0, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", fq.out_valid, 1'b1);
    chk("byp_pc", fq.out_pc, 64'h8000_0010);
    idle();
    chk("byp_count", count, 0);
    chk("byp_after_valid", fq.out_valid, 1'b0);
`else
    chk("nobyp_valid", fq.out_valid, 1'b0);
    drive(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("nobyp_late_valid", fq.out_valid, 1'b1);
    chk("nobyp_late_pc", fq.out_pc, 64'h8000_0010);
    idle();
    chk("nobyp_count", count, 0);
`endif

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        drive(1'b1, 64'h8000_4000, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h8000_4004, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", fq.out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
      end
      drive($urandom_range(0, 9) < 7, {$urandom(), $urandom()}, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
